// File: rtl/dac_spi_tx_pkg.sv
// Shared constants, state type and frame builder for the DAC serial path.
// Imported by dac_formato and dac_spi_tx.
package dac_spi_tx_pkg;

    localparam int          ANCHO_DEF     = 16;
    localparam int          RESOLUCION    = 14;
    localparam int          DAC_BITS      = 12;
    localparam int          TRAMA         = 16;
    localparam logic [1:0]  DAC_PD_NORMAL = 2'b00;
    localparam logic [4:0]  LAST_EDGE     = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_e;

    // Frame: two don't-care bits, power-down mode, then the code MSB first.
    function automatic logic [TRAMA-1:0] build_word(
        input logic [DAC_BITS-1:0] code
    );
        return {2'b00, DAC_PD_NORMAL, code};
    endfunction

endpackage

// File: rtl/dac_formato.sv
// Signed fixed-point sample to 12-bit offset-binary DAC code with saturation.
// Ports: data_in (ANCHO) in; code (12) out; sat out. Purely combinational.
module dac_formato
    import dac_spi_tx_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic [ANCHO-1:0]    data_in,
    output logic [DAC_BITS-1:0] code,
    output logic                sat
);

    logic [ANCHO-14:0] up;
    logic              up_all0;
    logic              up_all1;
    logic              unused_lsb;

    assign up         = data_in[ANCHO-1:13];
    assign up_all0    = ~|up;
    assign up_all1    = &up;
    // The two LSBs are truncated away.
    assign unused_lsb = ^data_in[1:0];

    always_comb begin
        code = {~data_in[13], data_in[12:2]};
        sat  = 1'b0;
        if (!(up_all0 || up_all1)) begin
            sat  = 1'b1;
            code = data_in[ANCHO-1] ? '0 : '1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// 3-wire serial transmitter of one 16-bit DAC frame per accepted sample.
// Ports: clk, reset (sync, active low), tx_start, data_In (ANCHO) in;
//        CS, SCLK, SDATA, tx_busy, tx_done_tick, sat out (all registered).
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF,
    parameter int DIV   = 2,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_start,
    input  logic [ANCHO-1:0] data_In,
    output logic             CS,
    output logic             SCLK,
    output logic             SDATA,
    output logic             tx_busy,
    output logic             tx_done_tick,
    output logic             sat
);

    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int HOLD_W = $clog2(HOLD + 1);

    logic [DAC_BITS-1:0] fmt_code;
    logic                fmt_sat;

    state_e              state_q, state_d;
    logic [TRAMA-1:0]    shreg_q, shreg_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [4:0]          edge_cnt_q, edge_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic                cs_q, cs_d;
    logic                sclk_q, sclk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                sat_q, sat_d;

    dac_formato #(
        .ANCHO (ANCHO)
    ) u_formato (
        .data_in (data_In),
        .code    (fmt_code),
        .sat     (fmt_sat)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        hold_cnt_d = hold_cnt_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sat_d      = sat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d    = ST_SHIFT;
                    shreg_d    = build_word(fmt_code);
                    sat_d      = fmt_sat;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    cs_d       = 1'b0;
                    sclk_d     = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_W'(DIV - 1)) begin
                    div_cnt_d = '0;
                    if (edge_cnt_q == LAST_EDGE) begin
                        // 32nd toggle closes the frame instead of raising SCLK.
                        state_d    = ST_HOLD;
                        shreg_d    = '0;
                        edge_cnt_d = '0;
                        hold_cnt_d = HOLD_W'(1);
                        cs_d       = 1'b1;
                        sclk_d     = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 5'd1;
                        sclk_d     = ~sclk_q;
                        // Advance data on rising SCLK, far from the sampling edge.
                        if (!sclk_q) begin
                            shreg_d = {shreg_q[TRAMA-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_W'(HOLD)) begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    busy_d     = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            hold_cnt_q <= '0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
        end
    end

    assign CS           = cs_q;
    assign SCLK         = sclk_q;
    assign SDATA        = shreg_q[TRAMA-1];
    assign tx_busy      = busy_q;
    assign tx_done_tick = done_q;
    assign sat          = sat_q;

endmodule
